can_tx_mailbox_sched: RTL
=========================

Name: can_tx_mailbox_sched

Overview:
- Multi-mailbox transmit scheduler that sits in front of the CAN frame serializer (bit-level TX engine) and owns its TX_REQ/TX_BUSY/TX_COMPLETE handshake.
- Software/host logic loads frames into NUM_MB mailboxes. The block picks the highest-priority pending frame (lowest ID), presents it to the serializer, tracks completion and reports per-mailbox done.

Parameters:
- NUM_MB, 4, number of transmit mailboxes (2..8).
- REQ_TIMEOUT, 16, cycles to wait for TX_BUSY after raising TX_REQ before abandoning the request.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- load_valid  in  1  write a frame into mailbox load_mb this cycle
- load_mb  in  $clog2(NUM_MB)  target mailbox index
- load_id  in  11  frame identifier
- load_dlc  in  4  data length code
- load_data  in  8x8  payload bytes [7:0][7:0]
- load_ready  out  1  high when load_mb is not the in-flight mailbox
- abort  in  NUM_MB  per-mailbox cancel request
- mb_pending  out  NUM_MB  mailbox holds an unsent frame
- done_valid  out  1  one-cycle pulse when a frame finishes
- done_mb  out  $clog2(NUM_MB)  mailbox of finished frame; valid with done_valid
- req_err  out  1  one-cycle pulse on REQ_TIMEOUT expiry
- TX_REQ  out  1  request to serializer
- TX_ID  out  11  identifier of selected frame
- TX_DLC  out  4  DLC of selected frame, clamped to 8
- TX_DATA  out  8x8  payload of selected frame
- TX_BUSY  in  1  serializer busy
- TX_COMPLETE  in  1  serializer end-of-frame flag

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0; mb_pending=0; TX_ID/TX_DLC/TX_DATA=0; timeout counter=0.
  - Mailbox contents are don't-care.
  - Reset during a frame abandons it; the serializer is reset separately.
- Load:
  - Accepted at a clock edge when load_valid && load_ready.
  - Stores id/dlc/data and sets mb_pending[load_mb]; visible next cycle.
  - A load to an already-pending, non-in-flight mailbox overwrites it.
  - A load with load_ready=0 is dropped and has no effect.
- DLC: values 9..15 are stored as-is and driven on TX_DLC as 8.
- Abort:
  - abort[i] clears mb_pending[i] unless i is in flight; the in-flight frame always completes.
  - Same-cycle load and abort to the same mailbox: the load wins and pending=1.
- Arbitration: the winner is the pending mailbox with the numerically lowest ID; ties go to the lowest mailbox index.
- FSM:
  - IDLE: if any mb_pending -> SELECT.
  - SELECT (1 cycle):
    - Registers the winner index, TX_ID, TX_DLC and TX_DATA; sets TX_REQ=1 -> REQ.
    - If the pending set becomes empty (abort) -> IDLE with no request.
  - REQ:
    - Holds TX_REQ and the frame fields stable and counts cycles.
    - On TX_BUSY=1: TX_REQ<=0 -> BUSY.
    - On counter reaching REQ_TIMEOUT-1: TX_REQ<=0, req_err pulse, mailbox stays pending -> IDLE.
  - BUSY:
    - Frame fields stay stable.
    - On TX_BUSY falling (TX_BUSY=0 in BUSY): clear mb_pending[winner], done_valid=1, done_mb=winner -> IDLE.
    - TX_COMPLETE is informational only; done keys on the TX_BUSY fall.
- Frames loaded while in REQ/BUSY do not pre-empt; they are considered at the next SELECT.
- load_ready=0 only for the in-flight mailbox, and only in REQ/BUSY.
- Latency:
  - Load at edge k into an idle block gives TX_REQ=1 after edge k+2.
  - Back-to-back frames: one IDLE cycle plus one SELECT cycle between the done pulse and the next TX_REQ.

Test Plan:
- Single frame: load mb0 id=0x123 dlc=2 data={0xA5,0x3C} -> TX_REQ high 2 cycles later with TX_ID=0x123, TX_DLC=2. Model serializer drops TX_BUSY -> done_valid pulse, done_mb=0, mb_pending=0.
- Priority: load mb0 id=0x400, mb1 id=0x010, mb2 id=0x010 in one burst -> service order mb1, mb2, mb0; three done pulses in that order.
- Abort: load mb0 id=0x100 and mb3 id=0x200; abort[3] while mb0 is in BUSY -> mb3 never requested, mb_pending=0 after mb0 done. abort[0] during BUSY -> mb0 still completes.
- Timeout: serializer never asserts TX_BUSY -> TX_REQ deasserts after 16 cycles, req_err pulse, mb_pending still set, retry TX_REQ 2 cycles later.
- DLC clamp plus load blocking: load dlc=12 -> TX_DLC=8. Load to the in-flight mailbox during BUSY -> load_ready=0 and contents unchanged.
- Async reset asserted mid-BUSY -> all outputs 0 immediately (before next clk edge), mb_pending=0, state IDLE.

Source files
------------

// File: rtl/can_tx_mailbox_sched.sv
// Transmit mailbox scheduler for a CAN serializer: picks the lowest-ID pending frame,
// runs the TX_REQ/TX_BUSY handshake and reports per-mailbox completion.
module can_tx_mailbox_sched #(
  parameter int unsigned NUM_MB      = 4,
  parameter int unsigned REQ_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  input  logic [$clog2(NUM_MB)-1:0] load_mb,
  input  logic [10:0]               load_id,
  input  logic [3:0]                load_dlc,
  input  logic [7:0][7:0]           load_data,
  output logic                      load_ready,
  input  logic [NUM_MB-1:0]         abort,
  output logic [NUM_MB-1:0]         mb_pending,
  output logic                      done_valid,
  output logic [$clog2(NUM_MB)-1:0] done_mb,
  output logic                      req_err,
  output logic                      TX_REQ,
  output logic [10:0]               TX_ID,
  output logic [3:0]                TX_DLC,
  output logic [7:0][7:0]           TX_DATA,
  input  logic                      TX_BUSY,
  input  logic                      TX_COMPLETE
);

  localparam int unsigned MB_W  = $clog2(NUM_MB);
  localparam int unsigned CNT_W = $clog2(REQ_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SELECT, REQ, BUSY} state_e;

  state_e              state_q, state_d;
  logic [MB_W-1:0]     win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_MB-1:0]   pend_q, pend_d;
  logic                tx_req_q, tx_req_d;
  logic [10:0]         tx_id_q, tx_id_d;
  logic [3:0]          tx_dlc_q, tx_dlc_d;
  logic [7:0][7:0]     tx_data_q, tx_data_d;
  logic                done_valid_q, done_valid_d;
  logic [MB_W-1:0]     done_mb_q, done_mb_d;
  logic                req_err_q, req_err_d;

  logic [10:0]         mb_id_q   [NUM_MB];
  logic [10:0]         mb_id_d   [NUM_MB];
  logic [3:0]          mb_dlc_q  [NUM_MB];
  logic [3:0]          mb_dlc_d  [NUM_MB];
  logic [7:0][7:0]     mb_data_q [NUM_MB];
  logic [7:0][7:0]     mb_data_d [NUM_MB];

  logic                in_flight;
  logic                load_fire;
  logic [NUM_MB-1:0]   load_hit;
  logic [NUM_MB-1:0]   cand;
  logic                best_found;
  logic [MB_W-1:0]     best_idx;
  logic [10:0]         best_id;
  logic                tx_complete_unused;

  // End-of-frame is keyed on the TX_BUSY fall; TX_COMPLETE is not needed.
  assign tx_complete_unused = TX_COMPLETE;

  assign in_flight  = (state_q == REQ) || (state_q == BUSY);
  assign load_ready = !rst && !(in_flight && (load_mb == win_q));
  assign load_fire  = load_valid && load_ready;

  // Mailboxes being aborted or rewritten this cycle are not eligible to win.
  always_comb begin
    load_hit = '0;
    if (load_fire) load_hit[load_mb] = 1'b1;
    cand       = pend_q & ~abort & ~load_hit;
    best_found = 1'b0;
    best_idx   = '0;
    best_id    = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (cand[i] && (!best_found || (mb_id_q[i] < best_id))) begin
        best_found = 1'b1;
        best_idx   = MB_W'(i);
        best_id    = mb_id_q[i];
      end
    end
  end

  always_comb begin
    mb_id_d   = mb_id_q;
    mb_dlc_d  = mb_dlc_q;
    mb_data_d = mb_data_q;
    if (load_fire) begin
      mb_id_d[load_mb]   = load_id;
      mb_dlc_d[load_mb]  = load_dlc;
      mb_data_d[load_mb] = load_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    tx_req_d     = tx_req_q;
    tx_id_d      = tx_id_q;
    tx_dlc_d     = tx_dlc_q;
    tx_data_d    = tx_data_q;
    done_valid_d = 1'b0;
    done_mb_d    = done_mb_q;
    req_err_d    = 1'b0;
    pend_d       = pend_q;

    for (int i = 0; i < NUM_MB; i++) begin
      if (abort[i] && !(in_flight && (MB_W'(i) == win_q))) pend_d[i] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|pend_q) state_d = SELECT;
      end
      SELECT: begin
        if (best_found) begin
          win_d     = best_idx;
          tx_id_d   = mb_id_q[best_idx];
          tx_dlc_d  = (mb_dlc_q[best_idx] > 4'd8) ? 4'd8 : mb_dlc_q[best_idx];
          tx_data_d = mb_data_q[best_idx];
          tx_req_d  = 1'b1;
          cnt_d     = '0;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (TX_BUSY) begin
          tx_req_d = 1'b0;
          state_d  = BUSY;
        end else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
          tx_req_d  = 1'b0;
          req_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BUSY: begin
        if (!TX_BUSY) begin
          pend_d[win_q] = 1'b0;
          done_valid_d  = 1'b1;
          done_mb_d     = win_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle load beats an abort of that mailbox.
    if (load_fire) pend_d[load_mb] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      tx_req_q     <= 1'b0;
      tx_id_q      <= '0;
      tx_dlc_q     <= '0;
      tx_data_q    <= '0;
      done_valid_q <= 1'b0;
      done_mb_q    <= '0;
      req_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      tx_req_q     <= tx_req_d;
      tx_id_q      <= tx_id_d;
      tx_dlc_q     <= tx_dlc_d;
      tx_data_q    <= tx_data_d;
      done_valid_q <= done_valid_d;
      done_mb_q    <= done_mb_d;
      req_err_q    <= req_err_d;
    end
  end

  // Mailbox payload storage carries no reset value.
  always_ff @(posedge clk) begin
    mb_id_q   <= mb_id_d;
    mb_dlc_q  <= mb_dlc_d;
    mb_data_q <= mb_data_d;
  end

  assign mb_pending = pend_q;
  assign done_valid = done_valid_q;
  assign done_mb    = done_mb_q;
  assign req_err    = req_err_q;
  assign TX_REQ     = tx_req_q;
  assign TX_ID      = tx_id_q;
  assign TX_DLC     = tx_dlc_q;
  assign TX_DATA    = tx_data_q;

endmodule
